sid_filter_sched: RTL and testbench
===================================

# sid_filter_sched

Time-multiplexes one shared SID filter datapath (stage-sequenced, single muladd) between `SIDS` SID instances. On each sample tick it runs a full 7-stage filter pass per instance, drives `stage` and the instance select, and keeps each instance's filter state (vlp, vbp, vhp) in local registers. It captures each instance's audio result and flags when a complete round is done. It sits between the per-SID register/voice logic and the filter datapath, and feeds the output mixer.

## Interface
- `SIDS`, default 2: number of SID instances sharing the filter; must be ≥1.
- `SEL_W`, default `$clog2(SIDS)` (min 1): width of `sid_sel`.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  sample strobe (one `clk` wide, ~1 MHz); requests one filter round.
- `stage`  out  3  stage index to the filter datapath; 0 = idle/writeback.
- `sid_sel`  out  `SEL_W`  instance being processed; selects that instance's `filter_i` fields upstream.
- `state_i`  in  `sid::filter_v_t` (72)  filter state output from datapath.
- `state_o`  out  `sid::filter_v_t` (72)  stored state of instance `sid_sel` to datapath `filter_i.state`; combinational mux.
- `audio_i`  in  `sid::s24_t`  audio output from datapath.
- `audio_o`  out  `sid::s24_t [SIDS]`  last completed audio sample per instance.
- `audio_valid`  out  1  one-cycle pulse: all `audio_o` updated for this round.
- `busy`  out  1  round in progress.
- `overrun`  out  1  one-cycle pulse: `tick` arrived while busy and was dropped.

## Operation
- FSM states:
  - IDLE: `stage` = 0, `busy` = 0.
  - RUN: `stage` 1..7.
  - WB: `stage` = 0, `busy` = 1.
- IDLE, `tick` = 1: next state RUN, `stage` ← 1, `sid_sel` ← 0.
- RUN: `stage` increments each cycle. From 7, go to WB (`stage` ← 0).
- WB for instance k, at the closing edge:
  - `state_mem[k]` ← `state_i`; `audio_o[k]` ← `audio_i`.
  - If k < SIDS−1: `sid_sel` ← k+1, `stage` ← 1, RUN.
  - Else: `sid_sel` ← 0, IDLE, `audio_valid` ← 1.
- `sid_sel` is constant for all 8 cycles (1..7, WB) of an instance.
- `state_o` = `state_mem[sid_sel]` at all times, including IDLE.
- State is stored opaquely as 72 bits; no arithmetic is performed on it.
- `tick` while `busy` = 1 (RUN or any WB): the tick is ignored and `overrun` pulses in the next cycle. The round is unaffected.
- `tick` in the `audio_valid` cycle (already IDLE) is accepted normally.
- Reset (asynchronous, any time, including mid-round):
  - `stage`, `sid_sel`, `busy`, `audio_valid`, `overrun` = 0.
  - All `state_mem` and `audio_o` entries = 0.
  - FSM = IDLE.
  - The first tick after reset starts at instance 0.

## Timing
- All outputs are registered except `state_o`, which is a mux of registers.
- With `tick` high in cycle n (IDLE):
  - `stage` = 1 and `busy` = 1 in cycle n+1.
  - Instance k occupies cycles n+1+8k … n+8+8k; its WB is cycle n+8+8k.
  - `audio_valid` = 1, `busy` = 0, and new `audio_o` are visible in cycle n+8·SIDS+1.
- Round length: 8·SIDS cycles. Max tick rate: one per 8·SIDS+1 cycles. SIDS=2 needs 17 cycles per tick.
- `audio_o[k]` holds between WBs; it is never cleared except by reset.

## Test plan
- Reset: hold `rst` with random inputs → `stage`=0, `sid_sel`=0, `busy`=0, `audio_valid`=0, `overrun`=0, `audio_o[*]`=0, `state_o`=0.
- Single tick, SIDS=2, tick at cycle 0 →
  - `stage` = 1,2,3,4,5,6,7,0 with `sid_sel`=0 over cycles 1–8.
  - `stage` = 1..7,0 with `sid_sel`=1 over cycles 9–16.
  - `audio_valid`=1 only in cycle 17; `busy` high in cycles 1–16.
- Writeback:
  - Stimulus: `audio_i`=0x123456 and `state_i`=72'hA in cycle 8; `audio_i`=0xABCDEF and `state_i`=72'hB in cycle 16.
  - Cycle 17: `audio_o[0]`=0x123456, `audio_o[1]`=0xABCDEF.
  - Next round: `state_o`=72'hA while `sid_sel`=0, and 72'hB while `sid_sel`=1.
- Overrun: ticks at cycles 0, 5 and 16 → `overrun` pulses in cycles 6 and 17; the round still ends with `audio_valid` in cycle 17.
- Back-to-back: ticks at cycles 0 and 17 → second round `stage`=1 in cycle 18; `audio_valid` in cycles 17 and 34; `overrun` never set.
- Mid-round reset: assert `rst` in cycle 12 (instance 1, stage 4) →
  - All outputs are 0 immediately (asynchronously).
  - The next tick after release gives `sid_sel`=0, `stage`=1, and `state_o`=0 for both instances.

Source files
------------

// File: rtl/sid_filter_sched.sv
// ---------------------------------------------------------------------------
// sid_filter_sched
//
// Purpose:
//   Lets several SID instances share one stage-sequenced filter datapath.
//   A sample tick starts a round. For each instance in turn, the block steps
//   the datapath through stages 1..7 and then one writeback cycle (stage 0).
//   In writeback it stores that instance's filter state and audio sample.
//   When the last instance has been written back, it pulses audio_valid.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   tick        sample strobe; requests one filter round
//   stage       stage index to the datapath (0 = idle / writeback)
//   sid_sel     instance currently being processed
//   state_i     filter state produced by the datapath
//   state_o     stored filter state of instance sid_sel (mux of registers)
//   audio_i     audio sample produced by the datapath
//   audio_o     last completed audio sample, one per instance
//   audio_valid one-cycle pulse: every audio_o entry updated this round
//   busy        round in progress
//   overrun     one-cycle pulse: a tick arrived while busy and was dropped
// ---------------------------------------------------------------------------

package sid;
    // Filter state (vlp, vbp, vhp). Kept opaque here; only the datapath
    // interprets the fields.
    typedef logic [71:0]        filter_v_t;
    typedef logic signed [23:0] s24_t;
endpackage

module sid_filter_sched #(
    parameter int SIDS  = 2,
    parameter int SEL_W = (SIDS > 1) ? $clog2(SIDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    output logic [2:0]       stage,
    output logic [SEL_W-1:0] sid_sel,
    input  sid::filter_v_t   state_i,
    output sid::filter_v_t   state_o,
    input  sid::s24_t        audio_i,
    output sid::s24_t        audio_o [SIDS],
    output logic             audio_valid,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } fsm_e;

    fsm_e             fsm_q;
    logic [2:0]       stage_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             last_inst;
    logic             busy_q;
    logic             valid_q;
    logic             overrun_q;
    sid::filter_v_t   state_mem_q [SIDS];
    sid::s24_t        audio_q     [SIDS];

    // Writeback of the last instance ends the round. Any other writeback
    // moves on to the next instance.
    always_comb begin
        last_inst = (sel_q == SEL_W'(SIDS - 1));
        sel_d     = last_inst ? '0 : sel_q + SEL_W'(1);
    end

    // Round sequencer. All outputs are registered here. The pulse outputs
    // default low every cycle, so each one lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= IDLE;
            stage_q   <= 3'd0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < SIDS; k++) begin
                state_mem_q[k] <= '0;
                audio_q[k]     <= '0;
            end
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;

            // A tick during a round is dropped. The round itself continues
            // undisturbed.
            if (tick && busy_q) begin
                overrun_q <= 1'b1;
            end

            case (fsm_q)
                IDLE: begin
                    if (tick) begin
                        fsm_q   <= RUN;
                        stage_q <= 3'd1;
                        sel_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                RUN: begin
                    if (stage_q == 3'd7) begin
                        fsm_q   <= WB;
                        stage_q <= 3'd0;
                    end else begin
                        stage_q <= stage_q + 3'd1;
                    end
                end

                WB: begin
                    state_mem_q[sel_q] <= state_i;
                    audio_q[sel_q]     <= audio_i;
                    sel_q              <= sel_d;
                    if (last_inst) begin
                        fsm_q   <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        fsm_q   <= RUN;
                        stage_q <= 3'd1;
                    end
                end

                default: begin
                    fsm_q   <= IDLE;
                    stage_q <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stored state of the selected instance goes back to the datapath. This
    // path is combinational so the datapath sees it from the first stage.
    always_comb begin
        state_o = state_mem_q[sel_q];
        for (int k = 0; k < SIDS; k++) begin
            audio_o[k] = audio_q[k];
        end
    end

    assign stage       = stage_q;
    assign sid_sel     = sel_q;
    assign busy        = busy_q;
    assign audio_valid = valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sid_filter_sched.sv
// ---------------------------------------------------------------------------
// tb_sid_filter_sched
//
// Purpose:
//   Self-checking bench for sid_filter_sched with SIDS = 2. A driver applies
//   directed and random stimulus. A reference model, written in terms of
//   round start cycles and cycle offsets, queues the expected outputs for
//   each cycle and the expected audio_valid events. A monitor on the falling
//   clock edge pops those entries and compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_sid_filter_sched;

    localparam int SIDS  = 2;
    localparam int SEL_W = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic [71:0]      stateIn = '0;
    logic [23:0]      audioIn = '0;
    logic [2:0]       stage;
    logic [SEL_W-1:0] sidSel;
    logic [71:0]      stateOut;
    sid::s24_t        audioOut [SIDS];
    logic             audioValid;
    logic             busy;
    logic             overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sid_filter_sched #(.SIDS(SIDS), .SEL_W(SEL_W)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .stage(stage),
        .sid_sel(sidSel),
        .state_i(stateIn),
        .state_o(stateOut),
        .audio_i(audioIn),
        .audio_o(audioOut),
        .audio_valid(audioValid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int                    cyc;
        logic [2:0]            stage;
        logic [SEL_W-1:0]      sel;
        logic                  busy;
        logic                  valid;
        logic                  ovr;
        logic [71:0]           st;
        logic [SIDS-1:0][23:0] aud;
    } exp_t;

    typedef struct packed {
        int                    cyc;
        logic [SIDS-1:0][23:0] aud;
    } evt_t;

    exp_t expQ[$];
    evt_t audQ[$];

    // Reference model state. A round that starts with a tick in cycle
    // roundStart covers cycles roundStart+1 .. roundStart+8*SIDS.
    int          roundStart = -1;
    logic [71:0] mMem [SIDS];
    logic [23:0] mAud [SIDS];
    bit          pendValid = 1'b0;
    bit          pendOvr   = 1'b0;
    bit          prevTick  = 1'b0;
    logic [23:0] prevAudio = '0;
    logic [71:0] prevState = '0;

    // Counts one comparison. Prints a single FAIL line when the values differ.
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    function automatic logic [71:0] randState();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[71:0];
    endfunction

    function automatic logic [23:0] randAudio();
        logic [31:0] r;
        r = $urandom();
        return r[23:0];
    endfunction

    // Puts the model back into its post-reset state.
    task automatic modelReset();
        roundStart = -1;
        for (int k = 0; k < SIDS; k++) begin
            mMem[k] = '0;
            mAud[k] = '0;
        end
        audQ.delete();
        pendValid = 1'b0;
        pendOvr   = 1'b0;
        prevTick  = 1'b0;
    endtask

    // Applies the inputs of cycle cyc-1 to the model, so that the model
    // describes the DUT as it appears in cycle cyc.
    task automatic modelStep();
        int  n;
        int  off;
        bit  inWin;
        evt_t ev;
        n         = cyc - 1;
        pendValid = 1'b0;
        pendOvr   = 1'b0;
        inWin     = (roundStart >= 0) && (n >= roundStart + 1) && (n <= roundStart + 8 * SIDS);
        if (inWin) begin
            off = n - roundStart - 1;
            if (off % 8 == 7) begin
                mMem[off / 8] = prevState;
                mAud[off / 8] = prevAudio;
                if (off / 8 == SIDS - 1) begin
                    pendValid = 1'b1;
                    ev.cyc = cyc;
                    for (int k = 0; k < SIDS; k++) ev.aud[k] = mAud[k];
                    audQ.push_back(ev);
                end
            end
        end
        if (prevTick) begin
            if (inWin) pendOvr = 1'b1;
            else       roundStart = n;
        end
    endtask

    // Advances one cycle. Updates the model, queues this cycle's expected
    // outputs, then drives the new inputs.
    task automatic applyStimulus(input bit tk, input logic [23:0] a, input logic [71:0] s);
        exp_t e;
        int   off;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) modelReset();
        else     modelStep();
        e.cyc   = cyc;
        e.stage = 3'd0;
        e.sel   = '0;
        e.busy  = 1'b0;
        if ((roundStart >= 0) && (cyc >= roundStart + 1) && (cyc <= roundStart + 8 * SIDS)) begin
            off    = cyc - roundStart - 1;
            e.stage = (off % 8 == 7) ? 3'd0 : 3'((off % 8) + 1);
            e.sel   = SEL_W'(off / 8);
            e.busy  = 1'b1;
        end
        e.valid = pendValid;
        e.ovr   = pendOvr;
        e.st    = mMem[int'(e.sel)];
        for (int k = 0; k < SIDS; k++) e.aud[k] = mAud[k];
        expQ.push_back(e);
        tick      = tk;
        audioIn   = a;
        stateIn   = s;
        prevTick  = tk;
        prevAudio = a;
        prevState = s;
    endtask

    task automatic stepRand(input bit tk);
        applyStimulus(tk, randAudio(), randState());
    endtask

    // Checks that every output is at its reset value.
    task automatic checkOutput(input string tag);
        check({tag, ".stage"}, 96'(stage), 96'(0));
        check({tag, ".sidSel"}, 96'(sidSel), 96'(0));
        check({tag, ".busy"}, 96'(busy), 96'(0));
        check({tag, ".audioValid"}, 96'(audioValid), 96'(0));
        check({tag, ".overrun"}, 96'(overrun), 96'(0));
        check({tag, ".stateOut"}, 96'(stateOut), 96'(0));
        for (int k = 0; k < SIDS; k++)
            check($sformatf("%s.audioOut%0d", tag, k), 96'($unsigned(audioOut[k])), 96'(0));
    endtask

    // Monitor. Compares one queued expectation per cycle. Each audio_valid
    // pulse is matched against the next queued round result.
    exp_t mE;
    evt_t mEv;
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            mE = expQ.pop_front();
            if (!rst) begin
                check("stage", 96'(stage), 96'(mE.stage));
                check("sidSel", 96'(sidSel), 96'(mE.sel));
                check("busy", 96'(busy), 96'(mE.busy));
                check("audioValid", 96'(audioValid), 96'(mE.valid));
                check("overrun", 96'(overrun), 96'(mE.ovr));
                check("stateOut", 96'(stateOut), 96'(mE.st));
                for (int k = 0; k < SIDS; k++)
                    check($sformatf("audioOut%0d", k), 96'($unsigned(audioOut[k])), 96'(mE.aud[k]));
            end
        end
        if (!rst && audioValid) begin
            if (audQ.size() == 0) begin
                check("validUnexpected", 96'(audioValid), 96'(0));
            end else begin
                mEv = audQ.pop_front();
                check("validCycle", 96'(cyc), 96'(mEv.cyc));
                for (int k = 0; k < SIDS; k++)
                    check($sformatf("roundAudio%0d", k), 96'($unsigned(audioOut[k])), 96'(mEv.aud[k]));
            end
        end
    end

    // Stops the run if the stimulus never reaches its end.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < SIDS; k++) begin
            mMem[k] = '0;
            mAud[k] = '0;
        end

        // Reset held while the inputs toggle randomly.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randAudio(), randState());
            checkOutput("resetHold");
        end
        stepRand(1'b0);
        rst = 1'b0;
        repeat (3) stepRand(1'b0);

        // Single round with known writeback values. A second round then
        // shows the stored state on state_o.
        for (int i = 0; i <= 20; i++) begin
            if (i == 8)       applyStimulus(1'b0, 24'h123456, 72'hA);
            else if (i == 16) applyStimulus(1'b0, 24'hABCDEF, 72'hB);
            else              stepRand(i == 0);
        end
        for (int i = 0; i <= 20; i++) stepRand(i == 0);

        // Overrun: ticks at offsets 0, 5 and 16.
        for (int i = 0; i <= 22; i++) stepRand(i == 0 || i == 5 || i == 16);

        // Back-to-back rounds: ticks at offsets 0 and 17.
        for (int i = 0; i <= 40; i++) stepRand(i == 0 || i == 17);

        // Mid-round reset during instance 1, stage 4.
        for (int i = 0; i <= 12; i++) stepRand(i == 0);
        #1 rst = 1'b1;
        #1 checkOutput("asyncReset");
        stepRand(1'b0);
        stepRand(1'b0);
        rst = 1'b0;
        stepRand(1'b0);
        for (int i = 0; i <= 20; i++) stepRand(i == 0);

        // Random traffic, including ticks that land mid-round.
        for (int i = 0; i < 1500; i++) stepRand($urandom_range(0, 5) == 0);

        for (int i = 0; i < 40; i++) stepRand(1'b0);
        @(posedge clk);
        #1;
        check("pendingRounds", 96'(audQ.size()), 96'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
